// File: rtl/alu_seq_param.sv
// alu_seq_param: parametrised handshaked ALU with a multi-cycle shift-add multiplier.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   request strobe, sampled only while busy=0
//   op[3:0]    opcode
//   A, B       WIDTH-bit operands, captured on accept
//   busy       registered; high while a MUL is in progress (requests are dropped)
//   out_valid  one-cycle pulse marking a new result
//   F, Fh      result / MUL product high half (Fh=0 after non-MUL ops)
//   c, z, o    carry, zero, signed-overflow flags
//   G, L, E    unsigned A>B, A<B, A==B of the accepted operands
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] Fh,
    output logic             c,
    output logic             z,
    output logic             o,
    output logic             G,
    output logic             L,
    output logic             E
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t r_state, w_next;

    logic                 r_busy, r_vld, r_cflag;
    logic [WIDTH-1:0]     r_F, r_Fh;
    logic                 r_c, r_z, r_o, r_G, r_L, r_E;
    logic [WIDTH-1:0]     r_mcand, r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_cmp;     // G/L/E held until the MUL completes

    logic                 w_accept;
    logic [WIDTH-1:0]     w_x, w_y, w_res;
    logic                 w_cin, w_c, w_o, w_ovf;
    logic [WIDTH:0]       w_sum, w_mstep;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_prod_hi;

    assign w_accept = in_valid && (r_state == S_IDLE);

    // Single-cycle datapath. One WIDTH+1 adder serves ADD/SUB/NEG/ADDC/SUBB;
    // subtraction is x + ~B + cin so c=1 means no borrow.
    always_comb begin
        w_x   = A;
        w_y   = B;
        w_cin = 1'b0;
        case (op)
            4'd1:    begin w_y = ~B; w_cin = 1'b1; end
            4'd2:    begin w_x = '0; w_y = ~B; w_cin = 1'b1; end
            4'd12:   w_cin = r_cflag;
            4'd13:   begin w_y = ~B; w_cin = r_cflag; end
            default: ;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
        w_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

        w_res = '0;
        w_c   = 1'b0;
        w_o   = 1'b0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd12, 4'd13: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_o   = w_ovf;
            end
            4'd3:    w_res = A & B;
            4'd4:    w_res = A ^ B;
            4'd5:    w_res = A | B;
            4'd6:    w_res = ~A;
            4'd7:    begin w_res = {A[0], A[WIDTH-1:1]};       w_c = A[0];       end
            4'd8:    begin w_res = {A[WIDTH-2:0], A[WIDTH-1]}; w_c = A[WIDTH-1]; end
            4'd9:    begin w_res = {1'b0, A[WIDTH-1:1]};       w_c = A[0];       end
            4'd10:   begin w_res = {A[WIDTH-2:0], 1'b0};       w_c = A[WIDTH-1]; end
            4'd14:   begin w_res = {A[WIDTH-1], A[WIDTH-1:1]}; w_c = A[0];       end
            4'd15:   w_res = A;
            default: ;
        endcase
    end

    // Multiplier step: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    // After WIDTH steps the accumulator holds the full product.
    assign w_mstep   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_acc_nxt = {w_mstep, r_acc[WIDTH-1:1]};
    assign w_prod_hi = w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && op == OP_MUL) w_next = S_MUL;
            S_MUL:   if (r_cnt == '0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_MUL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld    <= 1'b0;
            r_cflag  <= 1'b0;
            r_F      <= '0;
            r_Fh     <= '0;
            {r_c, r_z, r_o, r_G, r_L, r_E} <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_cmp    <= '0;
        end else begin
            r_vld <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (op == OP_MUL) begin
                        r_mcand  <= A;
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_cmp    <= {A > B, A < B, A == B};
                    end else begin
                        r_F     <= w_res;
                        r_Fh    <= '0;
                        r_c     <= w_c;
                        r_z     <= (w_res == '0);
                        r_o     <= w_o;
                        r_G     <= (A > B);
                        r_L     <= (A < B);
                        r_E     <= (A == B);
                        r_cflag <= w_c;
                        r_vld   <= 1'b1;
                    end
                end
            end else begin
                r_acc    <= w_acc_nxt;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_F     <= w_acc_nxt[WIDTH-1:0];
                    r_Fh    <= w_prod_hi;
                    r_c     <= |w_prod_hi;
                    r_z     <= (w_acc_nxt == '0);
                    r_o     <= 1'b0;
                    {r_G, r_L, r_E} <= r_cmp;
                    r_cflag <= |w_prod_hi;
                    r_vld   <= 1'b1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_vld;
    assign F         = r_F;
    assign Fh        = r_Fh;
    assign c         = r_c;
    assign z         = r_z;
    assign o         = r_o;
    assign G         = r_G;
    assign L         = r_L;
    assign E         = r_E;
endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param: an 8-bit instance for most scenarios and a
// 16-bit instance for the wide multiply / PASS cases.
module tb_alu_seq_param;
    logic clk, rst;
    // 8-bit instance
    logic       in_valid;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       busy, out_valid, c, z, ovf, g, l, e;
    logic [7:0] f, fh;
    logic [5:0] fl;
    // 16-bit instance
    logic        in_valid16;
    logic [3:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, out_valid16, c16, z16, ovf16, g16, l16, e16;
    logic [15:0] f16, fh16;
    logic [5:0]  fl16;

    int checks = 0;
    int errors = 0;

    assign fl   = {c, z, ovf, g, l, e};
    assign fl16 = {c16, z16, ovf16, g16, l16, e16};

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .A(a), .B(b),
        .busy(busy), .out_valid(out_valid), .F(f), .Fh(fh),
        .c(c), .z(z), .o(ovf), .G(g), .L(l), .E(e));

    alu_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .op(op16), .A(a16), .B(b16),
        .busy(busy16), .out_valid(out_valid16), .F(f16), .Fh(fh16),
        .c(c16), .z(z16), .o(ovf16), .G(g16), .L(l16), .E(e16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for exactly one edge; returns 1 time unit after that edge.
    task automatic issue(input logic [3:0] opc, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        in_valid = 1'b1; op = opc; a = av; b = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue16(input logic [3:0] opc, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        in_valid16 = 1'b1; op16 = opc; a16 = av; b16 = bv;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (f !== 8'h00 || fh !== 8'h00) begin errors++; $display("FAIL reset_F got F=%h Fh=%h want 00 00", f, fh); end
        checks++; if (fl !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", fl); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_hs got ov=%b busy=%b want 0 0", out_valid, busy); end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_add;
        issue(4'd0, 8'hFF, 8'h01);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", out_valid); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL add_F got %h want 00", f); end
        checks++; if (fl !== 6'b110100) begin errors++; $display("FAIL add_flags got %b want 110100", fl); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || f !== 8'h00) begin errors++; $display("FAIL add_pulse got ov=%b F=%h want 0 00", out_valid, f); end
    endtask

    task automatic test_addc;
        issue(4'd0, 8'h7F, 8'h01);
        checks++; if (f !== 8'h80 || fl !== 6'b001100) begin errors++; $display("FAIL addovf got F=%h fl=%b want 80 001100", f, fl); end
        issue(4'd12, 8'h00, 8'h00);
        checks++; if (out_valid !== 1'b1 || f !== 8'h00 || fl !== 6'b010001) begin errors++; $display("FAIL addc0 got ov=%b F=%h fl=%b want 1 00 010001", out_valid, f, fl); end
        issue(4'd0, 8'hFF, 8'h01);
        issue(4'd12, 8'h10, 8'h20);
        checks++; if (out_valid !== 1'b1 || f !== 8'h31 || fl !== 6'b000010) begin errors++; $display("FAIL addc1 got ov=%b F=%h fl=%b want 1 31 000010", out_valid, f, fl); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] tbl [0:9];
        logic [31:0] t;
        // {op, A, B, F, c, o, z, pad}
        tbl[0] = {4'd4,  8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = {4'd5,  8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = {4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = {4'd6,  8'h55, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = {4'd2,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = {4'd2,  8'h00, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = {4'd2,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = {4'd9,  8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = {4'd10, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9] = {4'd7,  8'h01, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            t = tbl[i];
            issue(t[31:28], t[27:20], t[19:12]);
            checks++;
            if (out_valid !== 1'b1 || f !== t[11:4] || {c, ovf, z} !== t[3:1]) begin
                errors++;
                $display("FAIL b2b_%0d got ov=%b F=%h coz=%b want 1 %h %b", i, out_valid, f, {c, ovf, z}, t[11:4], t[3:1]);
            end
        end
    endtask

    task automatic test_mul;
        int cyc;
        int extra;
        bit busy_ok;
        issue(4'd11, 8'hFF, 8'hFF);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_start got busy=%b ov=%b want 1 0", busy, out_valid); end
        cyc = 0; busy_ok = 1'b1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            if (cyc == 2) begin in_valid = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (out_valid !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (cyc != 8) begin errors++; $display("FAIL mul_latency got %0d want 8", cyc); end
        checks++; if (!busy_ok || busy !== 1'b0) begin errors++; $display("FAIL mul_busy got ok=%b end_busy=%b want 1 0", busy_ok, busy); end
        checks++; if (fh !== 8'hFE || f !== 8'h01) begin errors++; $display("FAIL mul_prod got %h%h want FE01", fh, f); end
        checks++; if (fl !== 6'b100001) begin errors++; $display("FAIL mul_flags got %b want 100001", fl); end
        extra = 0;
        repeat (4) begin @(posedge clk); #1; if (out_valid === 1'b1) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL mul_drop got %0d extra pulses want 0", extra); end
    endtask

    task automatic test_sub_shift;
        issue(4'd1, 8'h05, 8'h07);
        checks++; if (f !== 8'hFE || fh !== 8'h00 || fl !== 6'b000010) begin errors++; $display("FAIL sub got F=%h Fh=%h fl=%b want FE 00 000010", f, fh, fl); end
        issue(4'd14, 8'h81, 8'h00);
        checks++; if (f !== 8'hC0 || fl !== 6'b100100) begin errors++; $display("FAIL asr got F=%h fl=%b want C0 100100", f, fl); end
        issue(4'd8, 8'h80, 8'h00);
        checks++; if (f !== 8'h01 || fl !== 6'b100100) begin errors++; $display("FAIL rol got F=%h fl=%b want 01 100100", f, fl); end
    endtask

    task automatic test_mul_reset;
        int cyc;
        int pulses;
        issue(4'd11, 8'h12, 8'h34);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if (f !== 8'h00 || fh !== 8'h00 || fl !== 6'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_reset got F=%h Fh=%h fl=%b busy=%b ov=%b want all 0", f, fh, fl, busy, out_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (10) begin @(posedge clk); #1; if (out_valid === 1'b1) pulses++; end
        checks++; if (pulses != 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet got pulses=%0d busy=%b want 0 0", pulses, busy); end
        // cflag was 1 before reset; reset must have cleared it
        issue(4'd12, 8'h05, 8'h00);
        checks++; if (f !== 8'h05 || c !== 1'b0) begin errors++; $display("FAIL cflag_reset got F=%h c=%b want 05 0", f, c); end
        issue(4'd11, 8'h12, 8'h34);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != 8 || {fh, f} !== 16'h03A8) begin errors++; $display("FAIL mul2 got lat=%0d prod=%h want 8 03A8", cyc, {fh, f}); end
        checks++; if (fl !== 6'b100010) begin errors++; $display("FAIL mul2_flags got %b want 100010", fl); end
        issue(4'd13, 8'h05, 8'h03);
        checks++; if (f !== 8'h02 || fh !== 8'h00 || fl !== 6'b100100) begin errors++; $display("FAIL subb got F=%h Fh=%h fl=%b want 02 00 100100", f, fh, fl); end
    endtask

    task automatic test_w16;
        int cyc;
        issue16(4'd11, 16'hFFFF, 16'h0002);
        cyc = 0;
        while (out_valid16 !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != 16) begin errors++; $display("FAIL w16_latency got %0d want 16", cyc); end
        checks++; if (fh16 !== 16'h0001 || f16 !== 16'hFFFE || fl16 !== 6'b100100) begin
            errors++; $display("FAIL w16_mul got %h %h fl=%b want 0001 FFFE 100100", fh16, f16, fl16); end
        issue16(4'd15, 16'h0000, 16'h0005);
        checks++; if (f16 !== 16'h0000 || fh16 !== 16'h0000 || fl16 !== 6'b010010) begin
            errors++; $display("FAIL w16_pass_ne got F=%h Fh=%h fl=%b want 0000 0000 010010", f16, fh16, fl16); end
        issue16(4'd15, 16'h0000, 16'h0000);
        checks++; if (out_valid16 !== 1'b1 || fl16 !== 6'b010001) begin
            errors++; $display("FAIL w16_pass_eq got ov=%b fl=%b want 1 010001", out_valid16, fl16); end
    endtask

    initial begin
        in_valid = 1'b0; op = '0; a = '0; b = '0;
        in_valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        test_reset;
        test_add;
        test_addc;
        test_back_to_back;
        test_mul;
        test_sub_shift;
        test_mul_reset;
        test_w16;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
